nonce_sequencer: RTL

- Nonce-search controller sitting directly around SHAcomputationalBlock.
- Upstream role: builds `inputMsg` as {header prefix, nonce} and pulses `beginComputation`.
- Downstream role: waits for `computationComplete`, then compares `SHAoutput` against a target.
- Steps the nonce through a programmed range until a hash below target is found, the range is exhausted, the search is aborted, or the SHA block times out.

---
 rtl/miner_pkg.sv | 37 +++
 rtl/hash_target_compare.sv | 26 ++
 rtl/nonce_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
//
// Purpose:
//   Shared definitions for the mining datapath: default widths for the SHA
//   message, nonce and digest, the default WAIT timeout, and the nonce
//   sequencer state encoding.
//
// Contents:
//   MSG_W_DEFAULT        SHA message width (matches SHAcomputationalBlock)
//   NONCE_W_DEFAULT      nonce width, low bits of the message
//   HASH_W_DEFAULT       digest / target width
//   TIMEOUT_CYC_DEFAULT  cycles allowed in WAIT before giving up
//   seq_state_t          nonce sequencer FSM states
//   seq_is_busy()        true for the states that own the SHA block
// ---------------------------------------------------------------------------
package miner_pkg;

    localparam int MSG_W_DEFAULT       = 440;
    localparam int NONCE_W_DEFAULT     = 32;
    localparam int HASH_W_DEFAULT      = 256;
    localparam int TIMEOUT_CYC_DEFAULT = 512;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        WAIT,
        CHECK,
        DONE
    } seq_state_t;

    function automatic logic seq_is_busy(input seq_state_t s);
        return (s == LAUNCH) || (s == ARM) || (s == WAIT) || (s == CHECK);
    endfunction

endpackage

// File: rtl/hash_target_compare.sv
// ---------------------------------------------------------------------------
// hash_target_compare
//
// Purpose:
//   Purely combinational unsigned strict less-than between a digest and a
//   difficulty target. No input registers, so the caller decides where the
//   pipeline boundary sits (the pool-difficulty logic reuses this as is).
//
// Ports:
//   hash    in  W  digest under test
//   target  in  W  threshold
//   below   out 1  1 when hash < target (unsigned, strict)
// ---------------------------------------------------------------------------
module hash_target_compare
    import miner_pkg::*;
#(
    parameter int W = HASH_W_DEFAULT
) (
    input  logic [W-1:0] hash,
    input  logic [W-1:0] target,
    output logic         below
);

    assign below = (hash < target);

endmodule

// File: rtl/nonce_sequencer.sv
// ---------------------------------------------------------------------------
// nonce_sequencer
//
// Purpose:
//   Nonce-search controller wrapped around SHAcomputationalBlock. Builds the
//   message {prefix, nonce}, launches a hash, waits for completion, compares
//   the digest against the target and steps the nonce until a hit, range
//   exhaustion, abort, or a SHA timeout.
//
// Optional feature:
//   NONCE_SEQ_HASH_COUNT_EN  when defined, adds output hash_count[31:0], a
//                            saturating count of launches since the last
//                            accepted start.
//
// Ports:
//   clk                  in   1                rising-edge clock
//   n_rst                in   1                async active-low reset
//   start                in   1                begin search (IDLE/DONE only)
//   abort                in   1                return to IDLE (wins over all)
//   header_prefix        in   MSG_W-NONCE_W    upper message bits
//   nonce_start          in   NONCE_W          first nonce
//   nonce_end            in   NONCE_W          last nonce, inclusive
//   target               in   HASH_W           success threshold
//   inputMsg             out  MSG_W            {prefix_q, nonce_q} to SHA
//   beginComputation     out  1                launch pulse to SHA
//   computationComplete  in   1                SHA done level
//   SHAoutput            in   HASH_W           SHA digest
//   busy                 out  1                in LAUNCH/ARM/WAIT/CHECK
//   done                 out  1                in DONE
//   found                out  1                hit flag, valid with done
//   timeout_err          out  1                SHA timeout, valid with done
//   golden_nonce         out  NONCE_W          nonce of the last hit
//   hash_count           out  32               (optional) launch count
//   golden_hash          out  HASH_W           digest of the last hit
// ---------------------------------------------------------------------------
module nonce_sequencer
    import miner_pkg::*;
#(
    parameter int MSG_W       = MSG_W_DEFAULT,
    parameter int NONCE_W     = NONCE_W_DEFAULT,
    parameter int HASH_W      = HASH_W_DEFAULT,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [MSG_W-NONCE_W-1:0] header_prefix,
    input  logic [NONCE_W-1:0]       nonce_start,
    input  logic [NONCE_W-1:0]       nonce_end,
    input  logic [HASH_W-1:0]        target,
    output logic [MSG_W-1:0]         inputMsg,
    output logic                     beginComputation,
    input  logic                     computationComplete,
    input  logic [HASH_W-1:0]        SHAoutput,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic                     timeout_err,
    output logic [NONCE_W-1:0]       golden_nonce,
`ifdef NONCE_SEQ_HASH_COUNT_EN
    output logic [31:0]              hash_count,
`endif
    output logic [HASH_W-1:0]        golden_hash
);

    localparam int PREFIX_W = MSG_W - NONCE_W;
    localparam int TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    seq_state_t state;
    seq_state_t state_next;

    logic [PREFIX_W-1:0] prefix_q;
    logic [NONCE_W-1:0]  nonce_q;
    logic [NONCE_W-1:0]  end_q;
    logic [HASH_W-1:0]   target_q;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                found_q;
    logic                timeout_q;

    logic                accept_start;
    logic                tmo_clear;
    logic                tmo_inc;
    logic                timeout_hit;
    logic                hit;
    logic                nonce_inc;
    logic                hash_below;

    hash_target_compare #(
        .W      (HASH_W)
    ) u_compare (
        .hash   (SHAoutput),
        .target (target_q),
        .below  (hash_below)
    );

    // State register. Reset drops straight to IDLE so beginComputation,
    // being a decode of the state, falls without waiting for a clock.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes. Abort is tested first so it beats
    // a hit, a timeout and a same-cycle start. The range end is tested
    // before incrementing, so an all-ones end never wraps to zero.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        tmo_clear    = 1'b0;
        tmo_inc      = 1'b0;
        timeout_hit  = 1'b0;
        hit          = 1'b0;
        nonce_inc    = 1'b0;

        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        accept_start = 1'b1;
                        state_next   = LAUNCH;
                    end
                end
                LAUNCH: begin
                    state_next = ARM;
                end
                // A stale completion from the previous hash may still be
                // high here, so it is deliberately not looked at.
                ARM: begin
                    tmo_clear  = 1'b1;
                    state_next = WAIT;
                end
                WAIT: begin
                    if (computationComplete) begin
                        state_next = CHECK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_hit = 1'b1;
                        state_next  = DONE;
                    end else begin
                        tmo_inc = 1'b1;
                    end
                end
                CHECK: begin
                    if (hash_below) begin
                        hit        = 1'b1;
                        state_next = DONE;
                    end else if (nonce_q == end_q) begin
                        state_next = DONE;
                    end else begin
                        nonce_inc  = 1'b1;
                        state_next = LAUNCH;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Search context: captured on an accepted start, nonce stepped on a miss.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prefix_q <= '0;
            nonce_q  <= '0;
            end_q    <= '0;
            target_q <= '0;
        end else if (accept_start) begin
            prefix_q <= header_prefix;
            nonce_q  <= nonce_start;
            end_q    <= nonce_end;
            target_q <= target;
        end else if (nonce_inc) begin
            nonce_q  <= nonce_q + 1'b1;
        end
    end

    // WAIT watchdog, cleared in ARM so every hash gets the full budget.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt <= '0;
        end else if (tmo_clear) begin
            tmo_cnt <= '0;
        end else if (tmo_inc) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Result flags are only ever set on the transition into DONE and are
    // cleared on start or abort, so they read as valid whenever done is high.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else if (abort || accept_start) begin
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else if (hit) begin
            found_q   <= 1'b1;
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            found_q   <= 1'b0;
            timeout_q <= 1'b1;
        end
    end

    // Golden result survives abort and restarts; only a new hit replaces it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            golden_nonce <= '0;
            golden_hash  <= '0;
        end else if (hit) begin
            golden_nonce <= nonce_q;
            golden_hash  <= SHAoutput;
        end
    end

`ifdef NONCE_SEQ_HASH_COUNT_EN
    // Saturating launch counter; holds through DONE and abort.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hash_count <= '0;
        end else if (accept_start) begin
            hash_count <= '0;
        end else if ((state == LAUNCH) && (hash_count != 32'hFFFF_FFFF)) begin
            hash_count <= hash_count + 32'd1;
        end
    end
`endif

    assign inputMsg         = {prefix_q, nonce_q};
    assign beginComputation = (state == LAUNCH);
    assign busy             = seq_is_busy(state);
    assign done             = (state == DONE);
    assign found            = found_q;
    assign timeout_err      = timeout_q;

endmodule
